seq_shift_add_multiplier: RTL and testbench

//   Multi-cycle M x N shift-and-add multiplier with valid/ready handshakes on input and output.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_chunk_pp.sv | 22 ++
 rtl/seq_shift_add_multiplier.sv | 102 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam int M_DEF = 8;
  localparam int N_DEF = 8;
  localparam int K_DEF = 1;
  localparam int STEPS = N_DEF / K_DEF;
  localparam int CNT_W = $clog2(STEPS) + 1;

  function automatic int steps_f(input int n, input int k);
    return n / k;
  endfunction

  function automatic int cnt_w_f(input int n, input int k);
    return $clog2(n / k) + 1;
  endfunction

  // Magnitude of a w-bit two's complement value held in the low bits of v.
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [63:0] abs_val(input logic [63:0] v, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (v[w-1]) return (~v + 64'd1) & mask;
    return v & mask;
  endfunction

endpackage

// File: rtl/mul_chunk_pp.sv
// Partial product of the shifted multiplicand and one K-bit multiplier chunk.
module mul_chunk_pp #(
  parameter int W = 16,
  parameter int K = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [K-1:0] chunk_i,
  output logic [W-1:0] pp_o
);

  logic [W-1:0] terms [K];

  for (genvar j = 0; j < K; j++) begin : g_term
    assign terms[j] = chunk_i[j] ? (a_i << j) : '0;
  end

  always_comb begin
    pp_o = '0;
    for (int j = 0; j < K; j++) pp_o = pp_o + terms[j];
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle M x N shift-and-add multiplier, K bits per cycle, valid/ready on both sides.
module seq_shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int K          = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M+N-1:0] product,
  output logic           busy
);

  localparam int W       = M + N;
  localparam int STEPS_L = steps_f(N, K);
  localparam int CW      = cnt_w_f(N, K);

  if ((N % K) != 0 || !(K == 1 || K == 2 || K == 4)) begin : g_param_check
    $error("seq_shift_add_multiplier: K must be 1, 2 or 4 and divide N");
  end

  state_e         state_q;
  logic [W-1:0]   a_sh_q, acc_q, product_q;
  logic [N-1:0]   b_sh_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_q, out_valid_q;

  logic [M-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [W-1:0]   pp, acc_d;
  logic [N-1:0]   b_sh_d;
  logic           last;

  assign a_mag = signed_mode ? M'(abs_val(64'(a), M)) : a;
  assign b_mag = signed_mode ? N'(abs_val(64'(b), N)) : b;

  mul_chunk_pp #(.W(W), .K(K)) u_pp (
    .a_i     (a_sh_q),
    .chunk_i (b_sh_q[K-1:0]),
    .pp_o    (pp)
  );

  assign acc_d  = acc_q + pp;
  assign b_sh_d = b_sh_q >> K;
  // Early exit looks at the multiplier after this cycle's shift, so b=0 still costs one cycle.
  assign last   = (cnt_q == CW'(STEPS_L - 1)) || ((EARLY_EXIT != 0) && (b_sh_d == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_sh_q  <= W'(a_mag);
          b_sh_q  <= b_mag;
          neg_q   <= signed_mode & (a[M-1] ^ b[N-1]);
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          a_sh_q <= a_sh_q << K;
          b_sh_q <= b_sh_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            product_q   <= neg_q ? -acc_d : acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: four configurations, scoreboard of expected products/latencies.
module tb_seq_shift_add_multiplier;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [NC];
  logic        ir   [NC];
  logic        ov   [NC];
  logic        ordy [NC];
  logic        sm   [NC];
  logic        bz   [NC];
  logic [7:0]  a    [NC];
  logic [7:0]  b    [NC];
  logic [15:0] prod [NC];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          idx;
    logic [15:0] prod;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // cfg0: K=1 no early exit, cfg1: K=1 early exit, cfg2: K=2, cfg3: K=4
  seq_shift_add_multiplier #(.M(8), .N(8), .K(1), .EARLY_EXIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[0]), .b(b[0]),
    .signed_mode(sm[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .product(prod[0]), .busy(bz[0]));
  seq_shift_add_multiplier #(.M(8), .N(8), .K(1), .EARLY_EXIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[1]), .b(b[1]),
    .signed_mode(sm[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .product(prod[1]), .busy(bz[1]));
  seq_shift_add_multiplier #(.M(8), .N(8), .K(2), .EARLY_EXIT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(a[2]), .b(b[2]),
    .signed_mode(sm[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .product(prod[2]), .busy(bz[2]));
  seq_shift_add_multiplier #(.M(8), .N(8), .K(4), .EARLY_EXIT(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .a(a[3]), .b(b[3]),
    .signed_mode(sm[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .product(prod[3]), .busy(bz[3]));

  task automatic wait_result(input int idx, input int lat0);
    exp_t e;
    int   lat;
    lat = lat0;
    while (ov[idx] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    n_cmp++;
    if (ov[idx] !== 1'b1) begin
      n_bad++; $display("FAIL out_valid_timeout cfg%0d: got %b want 1", idx, ov[idx]);
    end
    n_cmp++;
    if (prod[idx] !== e.prod) begin
      n_bad++; $display("FAIL product cfg%0d: got 0x%04h want 0x%04h", idx, prod[idx], e.prod);
    end
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++; $display("FAIL latency cfg%0d: got %0d want %0d", idx, lat, e.lat);
    end
  endtask

  task automatic ack_result(input int idx);
    @(negedge clk);
    n_cmp++;
    if (ir[idx] !== 1'b0) begin
      n_bad++; $display("FAIL in_ready_in_done cfg%0d: got %b want 0", idx, ir[idx]);
    end
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
    n_cmp++;
    if (ov[idx] !== 1'b0 || bz[idx] !== 1'b0) begin
      n_bad++; $display("FAIL after_ack cfg%0d: got ov=%b busy=%b want 0/0", idx, ov[idx], bz[idx]);
    end
  endtask

  task automatic start_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic smv, input logic [15:0] ep, input int es);
    exp_t e;
    @(negedge clk);
    n_cmp++;
    if (ir[idx] !== 1'b1) begin
      n_bad++; $display("FAIL in_ready_idle cfg%0d: got %b want 1", idx, ir[idx]);
    end
    a[idx] = av; b[idx] = bv; sm[idx] = smv; iv[idx] = 1'b1;
    e.idx = idx; e.prod = ep; e.lat = es;
    sb.push_back(e);
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    a[idx] = 8'($urandom); b[idx] = 8'($urandom); sm[idx] = 1'($urandom);
  endtask

  task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                        input logic smv, input logic [15:0] ep, input int es);
    start_op(idx, av, bv, smv, ep, es);
    wait_result(idx, 0);
    ack_result(idx);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      n_cmp++;
      if (ov[i] !== 1'b0 || prod[i] !== 16'h0 || ir[i] !== 1'b1 || bz[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state cfg%0d: got ov=%b prod=0x%04h rdy=%b busy=%b want 0/0000/1/0",
                 i, ov[i], prod[i], ir[i], bz[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    run_op(0, 8'd13,  8'd11,  1'b0, 16'h008F, 8);
    run_op(0, 8'hFB,  8'd3,   1'b0, 16'h02F1, 8);
    run_op(0, 8'h80,  8'h80,  1'b0, 16'h4000, 8);
    run_op(0, 8'h00,  8'hFF,  1'b0, 16'h0000, 8);
    run_op(0, 8'hFF,  8'hFF,  1'b0, 16'hFE01, 8);
  endtask

  task automatic test_signed;
    run_op(0, 8'hFB, 8'd3,  1'b1, 16'hFFF1, 8);
    run_op(0, 8'h80, 8'h80, 1'b1, 16'h4000, 8);
    run_op(0, 8'd5,  8'hFF, 1'b1, 16'hFFFB, 8);
    run_op(1, 8'hFB, 8'd3,  1'b1, 16'hFFF1, 2);
  endtask

  task automatic test_early_exit;
    run_op(1, 8'd200, 8'd3,   1'b0, 16'h0258, 2);
    run_op(1, 8'h55,  8'h00,  1'b0, 16'h0000, 1);
    run_op(1, 8'd1,   8'h80,  1'b0, 16'h0080, 8);
    run_op(1, 8'h00,  8'hFF,  1'b0, 16'h0000, 8);
    run_op(1, 8'h80,  8'h80,  1'b1, 16'h4000, 8);
  endtask

  task automatic test_multibit;
    run_op(2, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 4);
    run_op(2, 8'h80, 8'h80, 1'b1, 16'h4000, 4);
    run_op(3, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 2);
    run_op(3, 8'hFB, 8'd3,  1'b1, 16'hFFF1, 2);
    run_op(3, 8'd100, 8'd200, 1'b0, 16'h4E20, 2);
  endtask

  task automatic test_stall;
    logic seen;
    start_op(0, 8'd6, 8'd7, 1'b0, 16'd42, 8);
    repeat (3) begin
      @(negedge clk); iv[0] = 1'b1; a[0] = 8'd1; b[0] = 8'd1;
      @(posedge clk); #1; iv[0] = 1'b0;
    end
    wait_result(0, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv[0] = (i % 2 == 0);
      n_cmp++;
      if (ov[0] !== 1'b1 || prod[0] !== 16'd42 || ir[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold cyc%0d: got ov=%b prod=0x%04h rdy=%b want 1/002a/0",
                 i, ov[0], prod[0], ir[0]);
      end
    end
    @(negedge clk); iv[0] = 1'b0;
    ack_result(0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0] !== 1'b0 || bz[0] !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL ignored_inputs_started_op: got activity=%b want 0", seen);
    end
    run_op(0, 8'd3, 8'd4, 1'b0, 16'd12, 8);
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    a[0] = 8'hFF; b[0] = 8'hFF; sm[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1; iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ov[0] !== 1'b0 || prod[0] !== 16'h0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid cfg0: got ov=%b prod=0x%04h rdy=%b busy=%b want 0/0000/1/0",
               ov[0], prod[0], ir[0], bz[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ov[0] !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL stale_result_after_reset: got out_valid seen=%b want 0", seen);
    end
    run_op(0, 8'd7, 8'd9, 1'b0, 16'd63, 8);
  endtask

  task automatic test_back_to_back;
    run_op(2, 8'd12, 8'd12, 1'b0, 16'd144, 4);
    run_op(2, 8'hF6, 8'hF6, 1'b1, 16'd100, 4);
    run_op(3, 8'h7F, 8'h80, 1'b1, 16'hC080, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NC; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; sm[i] = 1'b0; a[i] = 8'h0; b[i] = 8'h0;
    end
    test_reset;
    test_unsigned;
    test_signed;
    test_early_exit;
    test_multibit;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
